seg7_scan_controller: RTL and testbench

//  Time-multiplexes one shared BCD->7-segment decoder across NUM_DIGITS common-anode digits.
//  - Owns refresh timing, digit selection and anode drive.
//  - Provides a valid/ready load port with frame-boundary (tear-free) update.
//  - Optionally blanks leading zeros.
//  - Sits between the numeric datapath and the board display pins.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/bcd_to_seg7.sv | 33 +++
 rtl/seg7_scan_controller.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed 7-segment display path.
//   - SEG_BLANK and the active-low patterns for BCD digits 0..9,
//     bit order [6]=a ... [0]=g.
//   - Scan controller state encoding.
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0001100;

    typedef enum logic {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// ----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to active-low 7-segment decoder. Codes 10..15 have no
// glyph and produce a blank digit.
// Ports:
//   bcd  in   4  BCD digit
//   seg  out  7  active-low segments, [6]=a ... [0]=g
// ----------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// ----------------------------------------------------------------------------
// seg7_scan_controller
// Time-multiplexes one shared BCD decoder across NUM_DIGITS common-anode
// digits. New values arrive on a valid/ready port into a shadow register and
// are only copied to the displayed (active) register at a frame boundary, or
// straight away while the display is off, so a frame never shows a mix of
// old and new digits.
// Ports:
//   clk         in   1             system clock, rising edge
//   reset       in   1             asynchronous, active-high
//   enable      in   1             1 = scan display, 0 = display off
//   load_valid  in   1             load_data valid
//   load_ready  out  1             block can accept load_data
//   load_data   in   4*NUM_DIGITS  BCD digits, digit 0 in bits [3:0]
//   seg         out  7             active-low segments, [6]=a ... [0]=g
//   an          out  NUM_DIGITS    active-low anodes, an[i] drives digit i
// ----------------------------------------------------------------------------
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRE = PW'(REFRESH_DIV - 1);

    state_t                       state, state_nxt;
    logic [IW-1:0]                index, index_nxt;
    logic [PW-1:0]                prescaler, prescaler_nxt;
    logic [NUM_DIGITS-1:0][3:0]   active, active_nxt;
    logic [NUM_DIGITS-1:0][3:0]   shadow;
    logic                         pending, pending_nxt;
    logic                         out_of_reset;
    logic                         take;
    logic                         xfer;

    logic [NUM_DIGITS-1:0]        lz;
    logic [3:0]                   dec_in;
    logic [6:0]                   dec_out;
    logic [6:0]                   seg_nxt;
    logic [NUM_DIGITS-1:0]        an_nxt;

    // Ready is held low during reset and for the rest of the reset cycle;
    // out_of_reset rises on the first clock edge after release.
    assign load_ready = out_of_reset & ~pending;
    assign take       = load_valid & load_ready;

    // ------------------------------------------------------------------
    // Next-state: scan position and shadow->active transfer point
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        index_nxt     = index;
        prescaler_nxt = prescaler;
        xfer          = 1'b0;
        case (state)
            ST_OFF: begin
                index_nxt     = '0;
                prescaler_nxt = '0;
                // Nothing is on screen, so a waiting value can go live now.
                xfer          = pending;
                if (enable) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_nxt     = ST_OFF;
                    index_nxt     = '0;
                    prescaler_nxt = '0;
                end else if (prescaler == LAST_PRE) begin
                    prescaler_nxt = '0;
                    if (index == LAST_IDX) begin
                        index_nxt = '0;
                        // Frame wrap: the only tear-free update point while lit.
                        xfer      = pending;
                    end else begin
                        index_nxt = index + 1'b1;
                    end
                end else begin
                    prescaler_nxt = prescaler + 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_OFF;
                index_nxt     = '0;
                prescaler_nxt = '0;
            end
        endcase
    end

    assign active_nxt  = xfer ? shadow : active;
    // take and xfer are exclusive: take needs pending=0, xfer needs pending=1.
    assign pending_nxt = take | (pending & ~xfer);

    // ------------------------------------------------------------------
    // Leading-zero detect on the value that will be displayed next cycle.
    // lz[i] = digits i..NUM_DIGITS-1 are all zero.
    // ------------------------------------------------------------------
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = (active_nxt[NUM_DIGITS-1] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz[i] = lz[i+1] & (active_nxt[i] == 4'd0);
        end
    end

    // One decoder, steered by the digit that will be lit next cycle.
    assign dec_in = active_nxt[index_nxt];

    bcd_to_seg7 u_dec (
        .bcd (dec_in),
        .seg (dec_out)
    );

    // ------------------------------------------------------------------
    // Output selection. Outputs are registered from next-state values so
    // they line up with the state they describe. Prescaler position 0 is
    // the ghost-blank slot: anodes are all released while the segment
    // lines settle to the new digit.
    // ------------------------------------------------------------------
    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        if (state_nxt == ST_SCAN && prescaler_nxt != '0) begin
            an_nxt = ~(NUM_DIGITS'(1) << index_nxt);
            if (BLANK_LEADING && index_nxt != '0 && lz[index_nxt]) begin
                seg_nxt = SEG_BLANK;
            end else begin
                seg_nxt = dec_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_OFF;
            index        <= '0;
            prescaler    <= '0;
            active       <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            out_of_reset <= 1'b0;
            seg          <= SEG_BLANK;
            an           <= '1;
        end else begin
            state        <= state_nxt;
            index        <= index_nxt;
            prescaler    <= prescaler_nxt;
            active       <= active_nxt;
            pending      <= pending_nxt;
            out_of_reset <= 1'b1;
            seg          <= seg_nxt;
            an           <= an_nxt;
            if (take) begin
                shadow <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_controller
// Scoreboard bench. A driver process steps a reference model once per clock
// (display position derived from elapsed scan time, frame-boundary data
// update, handshake rules) and pushes the expected outputs for that cycle;
// an independent monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_seg7_scan_controller;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           enable;
    logic           load_valid;
    logic           load_ready;
    logic [4*N-1:0] load_data;
    logic [6:0]     seg;
    logic [N-1:0]   an;

    seg7_scan_controller #(
        .NUM_DIGITS    (N),
        .REFRESH_DIV   (RD),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         rdy;
        bit           chk_seg;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pushed = 0;
    int   popped = 0;

    // Reference model: scanning flag, cycles since scan start, data regs.
    bit          m_scan;
    int          m_sc;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pending;
    bit          m_live;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        m_scan    = 1'b0;
        m_sc      = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
        m_live    = 1'b0;
    endtask

    // Advance the model across one rising edge with the inputs seen there.
    task automatic model_edge(input bit rst, input bit en, input bit vld, input logic [15:0] d);
        bit hs;
        if (rst) begin
            model_reset();
        end else begin
            hs = vld && m_live && !m_pending;
            if (!m_scan) begin
                if (m_pending) begin
                    m_active  = m_shadow;
                    m_pending = 1'b0;
                end
                if (en) begin
                    m_scan = 1'b1;
                    m_sc   = 0;
                end
            end else if (!en) begin
                m_scan = 1'b0;
            end else begin
                m_sc++;
                if ((m_sc % FRAME) == 0 && m_pending) begin
                    m_active  = m_shadow;
                    m_pending = 1'b0;
                end
            end
            if (hs) begin
                m_shadow  = d;
                m_pending = 1'b1;
            end
            m_live = 1'b1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   pos, dg, ph, v;
        e.rdy     = m_live && !m_pending;
        e.an      = '1;
        e.seg     = 7'b1111111;
        e.chk_seg = 1'b1;
        if (m_scan) begin
            pos = m_sc % FRAME;
            dg  = pos / RD;
            ph  = pos % RD;
            if (ph == 0) begin
                e.chk_seg = 1'b0;   // ghost slot: only the anodes are defined
            end else begin
                e.an = ~(N'(1) << dg);
                v    = int'((m_active >> (4 * dg)) & 16'hF);
                if (dg > 0 && (m_active >> (4 * dg)) == 16'h0)
                    e.seg = 7'b1111111;
                else
                    e.seg = ref_seg(v);
            end
        end
        return e;
    endfunction

    task automatic step(input bit rst, input bit en, input bit vld, input logic [15:0] d);
        @(posedge clk);
        #1;
        model_edge(reset, enable, load_valid, load_data);
        exp_q.push_back(model_out());
        pushed++;
        reset      = rst;
        enable     = en;
        load_valid = vld;
        load_data  = d;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 16'h0);
    endtask

    // Present d until the model says the next edge accepts it.
    task automatic load(input logic [15:0] d, input bit en);
        bit done = 1'b0;
        step(1'b0, en, 1'b1, d);
        for (int n = 0; n < 200 && !done; n++) begin
            done = m_live && !m_pending;
            step(1'b0, en, !done, d);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: data %h never accepted", d);
        end
    endtask

    // Reset asserted between edges; outputs must drop without waiting for clk.
    task automatic async_reset();
        @(posedge clk);
        #1;
        model_edge(reset, enable, load_valid, load_data);
        #2;
        reset = 1'b1;
        model_reset();
        exp_q.push_back(model_out());
        pushed++;
        #1;
        chk("async_rst_an", an, {N{1'b1}});
        chk("async_rst_seg", seg, 7'b1111111);
        chk("async_rst_ready", load_ready, 1'b0);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] d = '0;
        int k;
        for (int i = 0; i < 4; i++) begin
            k = int'($urandom_range(0, 9));
            if (k < 3)       d[4*i +: 4] = 4'd0;
            else if (k == 9) d[4*i +: 4] = 4'($urandom_range(10, 15));
            else             d[4*i +: 4] = 4'($urandom_range(1, 9));
        end
        return d >> (4 * $urandom_range(0, 2));
    endfunction

    // Monitor: compare DUT outputs against the expectation for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                chk("an", an, e.an);
                if (e.chk_seg) chk("seg", seg, e.seg);
                chk("load_ready", load_ready, e.rdy);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit en_r;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("reset_an", an, {N{1'b1}});
        chk("reset_seg", seg, 7'b1111111);
        chk("reset_ready", load_ready, 1'b0);

        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 16'h9999);
        step(1'b0, 1'b1, 1'b0, 16'h0);       // release reset, enable scanning

        // Basic digits, leading-zero blanking, non-BCD code
        load(16'h1234, 1'b1);  run(3 * FRAME, 1'b1);
        load(16'h0070, 1'b1);  run(2 * FRAME, 1'b1);
        load(16'h0000, 1'b1);  run(2 * FRAME, 1'b1);
        load(16'h00A5, 1'b1);  run(2 * FRAME, 1'b1);

        // Mid-frame load followed by a held second load
        for (int i = 0; i < 64 && (m_sc % FRAME) != 6; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
        load(16'h4321, 1'b1);
        load(16'h5678, 1'b1);
        run(3 * FRAME, 1'b1);

        // Drop enable while digit 2 is lit, load while off, re-enable
        for (int i = 0; i < 64 && !(m_scan && (m_sc % FRAME) / RD == 2 && (m_sc % RD) == 2); i++)
            step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        run(3, 1'b0);
        load(16'h9087, 1'b0);
        run(3, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        run(2 * FRAME, 1'b1);

        // Asynchronous reset mid-digit, with a load left pending
        load(16'h3141, 1'b1);
        run(2, 1'b1);
        async_reset();
        step(1'b1, 1'b1, 1'b1, 16'h2222);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        run(5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        run(2 * FRAME, 1'b1);

        // Randomized traffic
        en_r = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 2) en_r = !en_r;
            if ($urandom_range(0, 999) < 3) begin
                async_reset();
                step(1'b1, en_r, 1'b0, 16'h0);
            end
            step(1'b0, en_r, ($urandom_range(0, 9) == 0), rand_bcd());
        end
        run(FRAME, 1'b1);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", popped, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
